// File: rtl/map_table_nway.sv
// N-way register-alias table: speculative + retired mappings, intra-group rename
// bypass, CDB ready tracking and single-cycle restore of speculative from retired.
module map_table_nway #(
  parameter int unsigned WAYS        = 2,
  parameter int unsigned RETIRE_WAYS = 2,
  parameter int unsigned CDB_PORTS   = 2,
  parameter int unsigned ARCH_REGS   = 32,
  parameter int unsigned PHYS_REGS   = 64,
  localparam int unsigned AW = $clog2(ARCH_REGS),
  localparam int unsigned PW = $clog2(PHYS_REGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WAYS*AW-1:0]        src1_arch,
  input  logic [WAYS*AW-1:0]        src2_arch,
  input  logic [WAYS*AW-1:0]        dest_arch,
  input  logic [WAYS-1:0]           rename_valid,
  input  logic [WAYS*PW-1:0]        new_pr,
  output logic [WAYS*PW-1:0]        src1_pr,
  output logic [WAYS*PW-1:0]        src2_pr,
  output logic [WAYS-1:0]           src1_rdy,
  output logic [WAYS-1:0]           src2_rdy,
  output logic [WAYS*PW-1:0]        old_pr,
  input  logic [CDB_PORTS-1:0]      cdb_valid,
  input  logic [CDB_PORTS*PW-1:0]   cdb_pr,
  input  logic [RETIRE_WAYS-1:0]    retire_valid,
  input  logic [RETIRE_WAYS*AW-1:0] retire_arch,
  input  logic [RETIRE_WAYS*PW-1:0] retire_pr,
  input  logic                      restore,
  output logic [ARCH_REGS*PW-1:0]   arch_pr
);

  logic [PW-1:0]        spec_pr   [ARCH_REGS];
  logic [PW-1:0]        spec_pr_n [ARCH_REGS];
  logic [PW-1:0]        ret_pr    [ARCH_REGS];
  logic [PW-1:0]        ret_pr_n  [ARCH_REGS];
  logic [ARCH_REGS-1:0] spec_rdy;
  logic [ARCH_REGS-1:0] spec_rdy_n;

  function automatic logic cdb_hit(input logic [PW-1:0] pr);
    cdb_hit = 1'b0;
    for (int c = 0; c < CDB_PORTS; c++) begin
      if (cdb_valid[c] && (cdb_pr[c*PW +: PW] == pr)) cdb_hit = 1'b1;
    end
  endfunction

  // Rename lookups: table read, then in-order bypass from older valid ways
  always_comb begin
    src1_pr  = '0;
    src2_pr  = '0;
    src1_rdy = '0;
    src2_rdy = '0;
    old_pr   = '0;
    for (int k = 0; k < WAYS; k++) begin
      src1_pr[k*PW +: PW] = spec_pr[src1_arch[k*AW +: AW]];
      src1_rdy[k] = spec_rdy[src1_arch[k*AW +: AW]] | cdb_hit(spec_pr[src1_arch[k*AW +: AW]]);
      src2_pr[k*PW +: PW] = spec_pr[src2_arch[k*AW +: AW]];
      src2_rdy[k] = spec_rdy[src2_arch[k*AW +: AW]] | cdb_hit(spec_pr[src2_arch[k*AW +: AW]]);
      if (dest_arch[k*AW +: AW] != '0) old_pr[k*PW +: PW] = spec_pr[dest_arch[k*AW +: AW]];
      for (int j = 0; j < k; j++) begin
        if (rename_valid[j] && (dest_arch[j*AW +: AW] != '0)) begin
          if (dest_arch[j*AW +: AW] == src1_arch[k*AW +: AW]) begin
            src1_pr[k*PW +: PW] = new_pr[j*PW +: PW];
            src1_rdy[k] = 1'b0;
          end
          if (dest_arch[j*AW +: AW] == src2_arch[k*AW +: AW]) begin
            src2_pr[k*PW +: PW] = new_pr[j*PW +: PW];
            src2_rdy[k] = 1'b0;
          end
          if (dest_arch[j*AW +: AW] == dest_arch[k*AW +: AW]) old_pr[k*PW +: PW] = new_pr[j*PW +: PW];
        end
      end
    end
  end

  // Retired-table next state; later ways overwrite earlier ones
  always_comb begin
    ret_pr_n = ret_pr;
    for (int r = 0; r < RETIRE_WAYS; r++) begin
      if (retire_valid[r] && (retire_arch[r*AW +: AW] != '0))
        ret_pr_n[retire_arch[r*AW +: AW]] = retire_pr[r*PW +: PW];
    end
  end

  // Speculative next state: CDB wakeup, then renames (youngest last), restore overrides
  always_comb begin
    spec_pr_n  = spec_pr;
    spec_rdy_n = spec_rdy;
    for (int i = 1; i < ARCH_REGS; i++) begin
      if (cdb_hit(spec_pr[i])) spec_rdy_n[i] = 1'b1;
    end
    for (int k = 0; k < WAYS; k++) begin
      if (rename_valid[k] && (dest_arch[k*AW +: AW] != '0)) begin
        spec_pr_n[dest_arch[k*AW +: AW]]  = new_pr[k*PW +: PW];
        spec_rdy_n[dest_arch[k*AW +: AW]] = cdb_hit(new_pr[k*PW +: PW]);
      end
    end
    if (restore) begin
      spec_pr_n  = ret_pr_n;
      spec_rdy_n = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_pr[i] <= PW'(i);
        ret_pr[i]  <= PW'(i);
      end
      spec_rdy <= '1;
    end else begin
      spec_pr  <= spec_pr_n;
      spec_rdy <= spec_rdy_n;
      ret_pr   <= ret_pr_n;
    end
  end

  always_comb begin
    arch_pr = '0;
    for (int i = 0; i < ARCH_REGS; i++) arch_pr[i*PW +: PW] = ret_pr[i];
  end

endmodule

// File: tb/tb_map_table_nway.sv
// Directed bench for map_table_nway: rename bypass, CDB wakeup, retire/restore, arch 0 and reset.
module tb_map_table_nway;
  localparam int unsigned AW = 5;
  localparam int unsigned PW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [2*AW-1:0] src1_arch, src2_arch, dest_arch;
  logic [1:0]    rename_valid;
  logic [2*PW-1:0] new_pr, src1_pr, src2_pr, old_pr;
  logic [1:0]    src1_rdy, src2_rdy;
  logic [1:0]    cdb_valid;
  logic [2*PW-1:0] cdb_pr;
  logic [1:0]    retire_valid;
  logic [2*AW-1:0] retire_arch;
  logic [2*PW-1:0] retire_pr;
  logic          restore;
  logic [32*PW-1:0] arch_pr;

  int checks   = 0;
  int failures = 0;

  map_table_nway dut (
    .clk(clk), .reset(reset),
    .src1_arch(src1_arch), .src2_arch(src2_arch), .dest_arch(dest_arch),
    .rename_valid(rename_valid), .new_pr(new_pr),
    .src1_pr(src1_pr), .src2_pr(src2_pr), .src1_rdy(src1_rdy), .src2_rdy(src2_rdy),
    .old_pr(old_pr),
    .cdb_valid(cdb_valid), .cdb_pr(cdb_pr),
    .retire_valid(retire_valid), .retire_arch(retire_arch), .retire_pr(retire_pr),
    .restore(restore), .arch_pr(arch_pr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    src1_arch = '0; src2_arch = '0; dest_arch = '0;
    rename_valid = '0; new_pr = '0;
    cdb_valid = '0; cdb_pr = '0;
    retire_valid = '0; retire_arch = '0; retire_pr = '0;
    restore = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] s1p(input int k);
    return 32'(src1_pr[k*PW +: PW]);
  endfunction
  function automatic logic [31:0] s2p(input int k);
    return 32'(src2_pr[k*PW +: PW]);
  endfunction
  function automatic logic [31:0] opr(input int k);
    return 32'(old_pr[k*PW +: PW]);
  endfunction
  function automatic logic [31:0] apr(input int i);
    return 32'(arch_pr[i*PW +: PW]);
  endfunction

  // Read arch reg a through way 0 source 1 and compare mapping and ready
  task automatic read_chk(input string tag, input int a, input int exp_pr, input logic exp_rdy);
    idle();
    src1_arch[0 +: AW] = AW'(a);
    #1;
    check({tag, "_pr"}, s1p(0), 32'(exp_pr));
    check({tag, "_rdy"}, 32'(src1_rdy[0]), 32'(exp_rdy));
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;

    // Reset identity mapping
    read_chk("reset_r5", 5, 5, 1'b1);
    check("reset_arch_pr5", apr(5), 32'd5);

    // Intra-group bypass: way0 writes r3, way1 (not renaming) reads r3
    idle();
    dest_arch[0 +: AW] = 5'd3; new_pr[0 +: PW] = 6'd40; rename_valid = 2'b01;
    src1_arch[AW +: AW] = 5'd3; dest_arch[AW +: AW] = 5'd3; new_pr[PW +: PW] = 6'd43;
    #1;
    check("byp_w1_src1_pr", s1p(1), 32'd40);
    check("byp_w1_src1_rdy", 32'(src1_rdy[1]), 32'd0);
    check("byp_w1_old_pr", opr(1), 32'd40);
    check("byp_w0_old_pr", opr(0), 32'd3);
    step();
    read_chk("r3_after", 3, 40, 1'b0);

    // CDB forwards ready combinationally and then into the table
    cdb_valid = 2'b10; cdb_pr[PW +: PW] = 6'd40;
    #1;
    check("cdb_fwd_rdy", 32'(src1_rdy[0]), 32'd1);
    check("cdb_fwd_pr", s1p(0), 32'd40);
    step();
    read_chk("cdb_stored", 3, 40, 1'b1);

    // Both ways rename r7: youngest wins table, old_pr chains
    idle();
    dest_arch[0 +: AW] = 5'd7; new_pr[0 +: PW] = 6'd41;
    dest_arch[AW +: AW] = 5'd7; new_pr[PW +: PW] = 6'd42;
    rename_valid = 2'b11;
    #1;
    check("dup_w0_old_pr", opr(0), 32'd7);
    check("dup_w1_old_pr", opr(1), 32'd41);
    step();
    read_chk("dup_r7", 7, 42, 1'b0);

    // Rename and matching broadcast in same cycle -> ready; unrelated broadcast -> not ready
    idle();
    dest_arch[0 +: AW] = 5'd9;  new_pr[0 +: PW] = 6'd44;
    dest_arch[AW +: AW] = 5'd10; new_pr[PW +: PW] = 6'd45;
    rename_valid = 2'b11;
    cdb_valid = 2'b11; cdb_pr[0 +: PW] = 6'd44; cdb_pr[PW +: PW] = 6'd40;
    step();
    read_chk("ren_cdb_r9", 9, 44, 1'b1);
    read_chk("ren_nocdb_r10", 10, 45, 1'b0);

    // Retire r7 twice plus restore; a same-cycle rename is discarded
    idle();
    retire_valid = 2'b11;
    retire_arch[0 +: AW] = 5'd7; retire_pr[0 +: PW] = 6'd41;
    retire_arch[AW +: AW] = 5'd7; retire_pr[PW +: PW] = 6'd42;
    restore = 1'b1;
    dest_arch[0 +: AW] = 5'd8; new_pr[0 +: PW] = 6'd46; rename_valid = 2'b01;
    step();
    idle();
    check("restore_arch_pr7", apr(7), 32'd42);
    check("restore_arch_pr8", apr(8), 32'd8);
    for (int i = 0; i < 32; i++) begin
      src1_arch[0 +: AW] = AW'(i);
      #1;
      check($sformatf("restore_spec_r%0d", i), s1p(0), (i == 7) ? 32'd42 : 32'(i));
      check($sformatf("restore_rdy_r%0d", i), 32'(src1_rdy[0]), 32'd1);
    end

    // Arch 0: no write, no bypass, reads PR 0 ready
    idle();
    dest_arch[0 +: AW] = 5'd0; new_pr[0 +: PW] = 6'd50; rename_valid = 2'b01;
    src2_arch[0 +: AW] = 5'd0; src1_arch[AW +: AW] = 5'd0;
    #1;
    check("r0_w0_src2_pr", s2p(0), 32'd0);
    check("r0_w0_src2_rdy", 32'(src2_rdy[0]), 32'd1);
    check("r0_w0_old_pr", opr(0), 32'd0);
    check("r0_w1_src1_pr", s1p(1), 32'd0);
    check("r0_w1_src1_rdy", 32'(src1_rdy[1]), 32'd1);
    step();
    read_chk("r0_after", 0, 0, 1'b1);

    // Reset during rename/retire/restore yields clean identity state
    idle();
    dest_arch[0 +: AW] = 5'd5; new_pr[0 +: PW] = 6'd51; rename_valid = 2'b01;
    retire_valid = 2'b01; retire_arch[0 +: AW] = 5'd7; retire_pr[0 +: PW] = 6'd52;
    restore = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    read_chk("rst_r5", 5, 5, 1'b1);
    read_chk("rst_r7", 7, 7, 1'b1);
    for (int i = 0; i < 32; i++) check($sformatf("rst_arch_pr%0d", i), apr(i), 32'(i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/map_table_nway.md
Name: map_table_nway

Overview:
- N-way superscalar register-alias table for the out-of-order core.
- Renames up to WAYS instructions per cycle, with intra-group dependency bypass, and retires up to RETIRE_WAYS mappings per cycle.
- Accepts CDB_PORTS ready broadcasts per cycle and keeps a speculative table plus a retired (architectural) table for one-cycle branch/exception recovery.
- Sits between decode/dispatch (consumer of rename results), the free list (supplier of new PRs) and the ROB (retire/restore source).

Parameters:
WAYS, 2, instructions renamed per cycle
RETIRE_WAYS, 2, mappings committed per cycle
CDB_PORTS, 2, ready broadcasts per cycle
ARCH_REGS, 32, architectural registers; index 0 is hardwired zero
PHYS_REGS, 64, physical registers; must be >= ARCH_REGS
AW, $clog2(ARCH_REGS), arch index width (derived)
PW, $clog2(PHYS_REGS), phys index width (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
src1_arch  in  WAYS*AW  source-1 arch index per way
src2_arch  in  WAYS*AW  source-2 arch index per way
dest_arch  in  WAYS*AW  destination arch index per way
rename_valid  in  WAYS  way k carries a renaming instruction
new_pr  in  WAYS*PW  free-list PR allocated to way k
src1_pr, src2_pr  out  WAYS*PW  renamed sources
src1_rdy, src2_rdy  out  WAYS  source-ready bits
old_pr  out  WAYS*PW  previous mapping of dest_arch (for ROB free-on-retire)
cdb_valid  in  CDB_PORTS  broadcast valid
cdb_pr  in  CDB_PORTS*PW  broadcast PR
retire_valid  in  RETIRE_WAYS  commit enable, way 0 oldest
retire_arch  in  RETIRE_WAYS*AW  committed arch reg
retire_pr  in  RETIRE_WAYS*PW  committed PR
restore  in  1  flush: speculative table <- retired table
arch_pr  out  ARCH_REGS*PW  retired-table snapshot (debug/commit view)

Behaviour:
- State: spec_pr/spec_rdy[ARCH_REGS] and ret_pr[ARCH_REGS].
- Reset: entry i maps to PR i with ready=1 in both tables; all outputs reflect this combinationally in the following cycle.
- Entry 0 is never written. Any read of arch 0 returns PR 0, ready=1. Rename with dest_arch=0 does not write the table; old_pr returns 0.
- Rename reads are combinational on the current table, then bypassed in order:
  - Way k source/old_pr lookups check older ways j<k with rename_valid[j] and a matching nonzero dest_arch[j].
  - The youngest such j wins: PR=new_pr[j], ready=0.
  - Otherwise the table value is used, with ready forced to 1 if any cdb_valid/cdb_pr matches the table PR.
- Rename writes at posedge: spec entry <- new_pr, ready=0. If multiple ways target the same arch reg, the youngest way wins.
- CDB at posedge: every spec entry whose PR matches any valid cdb_pr gets ready=1. A rename write in the same cycle to that entry takes precedence (ready=0), unless new_pr equals a broadcast PR, in which case ready=1.
- Retire at posedge: ret_pr[retire_arch] <- retire_pr. Same-cycle duplicate arch regs: the highest-index (youngest) way wins. arch 0 is ignored.
- Restore at posedge:
  - spec_pr <- retired table including this cycle's retire writes.
  - spec_rdy <- 1 for all entries; retired values are by definition complete.
  - Renames in the same cycle are discarded. CDB in the same cycle is irrelevant.
- Reset has priority over everything. Reset mid-rename or mid-restore yields the clean reset state with no partial update.
- Latency: rename outputs 0 cycles (combinational); table updates visible the next cycle.
- No internal backpressure: the caller guarantees new_pr validity.

Test Plan:
- Reset, then read src1_arch=5 -> src1_pr=5, src1_rdy=1; arch_pr[5]=5.
- Way0 dest r3 new_pr=40, way1 src1=r3 same cycle -> way1 src1_pr=40, rdy=0; way1 old_pr for dest r3 = 40. Next cycle, read r3 -> 40, rdy=0.
- Entry r3=40 not ready, cdb_pr[1]=40 valid while way0 reads r3 -> src1_rdy=1 same cycle; next cycle stored ready=1.
- Way0 and way1 both dest r7 with PRs 41/42 -> table r7=42; way1 old_pr=41; way0 old_pr=7.
- retire r7->41 and r7->42 on ways 0/1 with restore the same cycle -> next cycle spec r7=42 ready=1, arch_pr[7]=42, and all other spec entries equal retired.
- Rename dest r0 new_pr=50 with src r0 -> src_pr=0, rdy=1; table entry 0 unchanged. Assert reset during a rename -> all entries identity/ready.
